// File: rtl/alu_issue_ctrl_if.sv
// Handshake and data bundle between the decode stage, the issue/retire
// controller, the external alu32bit and the downstream consumer.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
) ();
  // upstream op
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  // ALU side
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  // downstream result
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;

  // environment side: upstream producer, ALU and downstream consumer
  modport master (
    output in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_control,
    input  out_valid, out_result, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_control,
    output out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/retire controller in front of alu32bit: S1 drives the ALU,
// S2 registers its result for a valid/ready consumer.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  alu_issue_ctrl_if.slave    bus,
  output logic [15:0]        retire_count
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctl_e;

  // issue stage
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             ill_q, ill_d;
  // retire stage
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             oill_q, oill_d;
  logic [15:0]      cnt_q, cnt_d;

  alu_ctl_e         dec_ctl;
  logic             dec_ill;
  logic [WIDTH-1:0] op_b;
  logic             s2_take;
  logic             in_ready;
  logic             accept;
  logic             out_hs;

  // Undefined encodings still run through the ALU as an add so the
  // pipeline timing is identical; only the illegal tag marks them.
  always_comb begin
    dec_ctl = ALU_ADD;
    dec_ill = 1'b0;
    case (bus.alu_op)
      2'b00: dec_ctl = ALU_ADD;
      2'b01: dec_ctl = ALU_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000: dec_ctl = ALU_ADD;
          6'b100010: dec_ctl = ALU_SUB;
          6'b100100: dec_ctl = ALU_AND;
          6'b100101: dec_ctl = ALU_OR;
          6'b101010: dec_ctl = ALU_SLT;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign op_b     = bus.alu_src ? bus.imm : bus.rt_data;
  assign s2_take  = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign in_ready = ~reset & ~flush & (~s1_valid_q | s2_take);
  assign accept   = bus.in_valid & in_ready;
  assign out_hs   = out_valid_q & bus.out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    ctl_d       = ctl_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    oill_d      = oill_q;
    cnt_d       = cnt_q;

    // a consumer handshake in a flush cycle still retires its op
    if (out_hs) cnt_d = cnt_q + 16'd1;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        a_d        = bus.rs_data;
        b_d        = op_b;
        ctl_d      = dec_ctl;
        ill_d      = dec_ill;
      end else if (s2_take) begin
        s1_valid_d = 1'b0;
      end

      if (s2_take) begin
        out_valid_d = 1'b1;
        res_d       = bus.alu_result;
        zero_d      = bus.alu_zero;
        oill_d      = ill_q;
      end else if (out_hs) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= 4'b0000;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      oill_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctl_q       <= ctl_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      oill_q      <= oill_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = ctl_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = res_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = oill_q;
  assign retire_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios plus random ops with
// random backpressure and flushes, checked against an op-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] retire_count;

  alu_issue_ctrl_if #(.WIDTH(32)) bus ();

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  // stand-in for alu32bit, driven from the controller's ALU outputs
  logic [31:0] alu_r;
  always_comb begin
    case (bus.alu_control)
      4'b0000: alu_r = bus.alu_a & bus.alu_b;
      4'b0001: alu_r = bus.alu_a | bus.alu_b;
      4'b0010: alu_r = bus.alu_a + bus.alu_b;
      4'b0110: alu_r = bus.alu_a - bus.alu_b;
      4'b0111: alu_r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: alu_r = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 32'd0);

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] exp_cnt = 16'd0;

  // op-level meaning of an instruction, independent of control codes
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   kind;  // 0 add, 1 sub, 2 and, 3 or, 4 slt
    kind  = 0;
    e.ill = 1'b0;
    if (op == 2'd1) kind = 1;
    else if (op == 2'd3) e.ill = 1'b1;
    else if (op == 2'd2) begin
      if      (fn == 6'h20) kind = 0;
      else if (fn == 6'h22) kind = 1;
      else if (fn == 6'h24) kind = 2;
      else if (fn == 6'h25) kind = 3;
      else if (fn == 6'h2A) kind = 4;
      else e.ill = 1'b1;
    end
    case (kind)
      1:       e.res = a - b;
      2:       e.res = a & b;
      3:       e.res = a | b;
      4:       e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = a + b;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // monitor: pops the scoreboard on each consumer handshake
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_cnt    = 16'd0;
      prev_stall = 1'b0;
    end else begin
      chk("retire_count", {16'd0, retire_count}, {16'd0, exp_cnt});
      if (prev_stall)
        chk("held_output", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_result},
            {1'b1, prev_out});
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h with no op in flight", bus.out_result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({bus.out_result, bus.out_zero, bus.out_illegal} !== e) begin
            errors++;
            $display("FAIL result: got res=%h z=%b ill=%b want res=%h z=%b ill=%b",
                     bus.out_result, bus.out_zero, bus.out_illegal, e.res, e.zero, e.ill);
          end
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_out   = {bus.out_illegal, bus.out_zero, bus.out_result};
      if (flush) exp_q.delete();
    end
  end

  // offer one op until accepted; rnd randomizes out_ready/flush each cycle
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] rt, input logic [31:0] im, input logic src,
                      input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.rs_data  = a;
    bus.rt_data  = rt;
    bus.imm      = im;
    bus.alu_src  = src;
    while (!done) begin
      if (rnd) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        flush         = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(op, fn, a, src ? im : rt));
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        vectors++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want 1", n);
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (rnd) flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] base;
  logic [5:0]  fpick;
  logic [5:0]  legal_f [5];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'd0;
    bus.funct     = 6'd0;
    bus.rs_data   = 32'd0;
    bus.rt_data   = 32'd0;
    bus.imm       = 32'd0;
    bus.alu_src   = 1'b0;
    bus.out_ready = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",    {31'd0, bus.in_ready},    32'd0);
    chk("rst_out_valid",   {31'd0, bus.out_valid},   32'd0);
    chk("rst_out_result",  bus.out_result,           32'd0);
    chk("rst_out_flags",   {30'd0, bus.out_zero, bus.out_illegal}, 32'd0);
    chk("rst_alu_a",       bus.alu_a,                32'd0);
    chk("rst_alu_b",       bus.alu_b,                32'd0);
    chk("rst_alu_control", {28'd0, bus.alu_control}, 32'd0);
    chk("rst_retire",      {16'd0, retire_count},    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // R-type AND: latency and control code
    send(2'd2, 6'h24, 32'h0110_1111, 32'h0000_1111, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("and_alu_control", {28'd0, bus.alu_control}, 32'h0);
    chk("and_alu_a", bus.alu_a, 32'h0110_1111);
    chk("and_alu_b", bus.alu_b, 32'h0000_1111);
    @(posedge clk); #1;
    @(negedge clk);
    chk("and_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("and_out_result", bus.out_result, 32'h0000_1111);
    chk("and_out_zero", {31'd0, bus.out_zero}, 32'd0);
    idle(2);

    // back-to-back add, sub, slt; imm path used for the add
    base = exp_cnt;
    send(2'd0, 6'h00, 32'h1010_1111, 32'd0, 32'h0110_1111, 1'b1, 1'b0);
    send(2'd1, 6'h00, 32'h1010_1111, 32'h1010_1111, 32'd0, 1'b0, 1'b0);
    send(2'd2, 6'h2A, 32'h0000_1111, 32'h0110_1111, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_sub_result", bus.out_result, 32'h0000_0000);
    chk("b2b_sub_zero", {31'd0, bus.out_zero}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_slt_result", bus.out_result, 32'h0000_0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_retire_count", {16'd0, retire_count}, {16'd0, base + 16'd3});
    @(posedge clk); #1;

    // backpressure: third op must be refused
    bus.out_ready = 1'b0;
    send(2'd0, 6'h00, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    send(2'd1, 6'h00, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'd0;
    @(negedge clk);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_first_result", bus.out_result, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send(2'd2, 6'h25, 32'h00F0_0000, 32'h0000_000F, 32'd0, 1'b0, 1'b0);
    idle(4);

    // illegal encodings
    send(2'd2, 6'h00, 32'd7, 32'd8, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ill_funct_control", {28'd0, bus.alu_control}, 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_funct_flag", {31'd0, bus.out_illegal}, 32'd1);
    @(posedge clk); #1;
    send(2'd3, 6'h20, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ill_op_control", {28'd0, bus.alu_control}, 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_op_flag", {31'd0, bus.out_illegal}, 32'd1);
    idle(2);

    // flush with both stages full
    bus.out_ready = 1'b0;
    send(2'd0, 6'h00, 32'd11, 32'd22, 32'd0, 1'b0, 1'b0);
    send(2'd0, 6'h00, 32'd33, 32'd44, 32'd0, 1'b0, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    idle(4);

    // random traffic with random backpressure and flushes
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        idle(1);
      end
      if ($urandom_range(0, 3) == 0) fpick = 6'($urandom);
      else fpick = legal_f[$urandom_range(0, 4)];
      send(2'($urandom), fpick, $urandom, $urandom, $urandom, 1'($urandom), 1'b1);
    end

    // drain
    bus.out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_remaining", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage issue/retire controller sitting in front of `alu32bit` in the 32-bit pipeline. It accepts decoded operations over a valid/ready handshake and derives the 4-bit ALU control code from `alu_op`/`funct`. It drives the ALU operands from an issue register, then captures `Result`/`Zeroflag` into a retire register presented downstream with its own valid/ready handshake. Throughput is one op per cycle, with full backpressure and flush support.

## Interface
- `WIDTH`, default 32, operand/result width (ALU is fixed at 32; other values unsupported).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  upstream op valid.
- `in_ready`  out  1  block can accept op this cycle.
- `alu_op`  in  2  00 add (load/store), 01 sub (branch), 10 R-type by funct, 11 illegal.
- `funct`  in  6  R-type function field.
- `rs_data`  in  32  operand A.
- `rt_data`  in  32  register operand B.
- `imm`  in  32  sign-extended immediate.
- `alu_src`  in  1  1: B = `imm`, 0: B = `rt_data`.
- `alu_a`  out  32  to ALU `a`.
- `alu_b`  out  32  to ALU `b`.
- `alu_control`  out  4  to ALU `ALUControl`.
- `alu_result`  in  32  from ALU `Result`.
- `alu_zero`  in  1  from ALU `Zeroflag`.
- `out_valid`  out  1  retire register holds a result.
- `out_ready`  in  1  downstream accepts result.
- `out_result`  out  32  registered result.
- `out_zero`  out  1  registered zero flag.
- `out_illegal`  out  1  op had an undefined encoding.
- `retire_count`  out  16  ops retired since reset; wraps.

## Operation
- ALU codes: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 set-on-less-than.
- `alu_op` decode:
  - 00 → 0010.
  - 01 → 0110.
  - 10, by `funct`: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - Any other `funct`, or `alu_op` = 11 → code 0010 with the illegal bit set.
- Decode happens at accept. The code and illegal bit are stored in the issue register.
- Issue stage (S1) holds `s1_valid`, A, B (muxed by `alu_src` at accept), the code, and the illegal bit. `alu_a`/`alu_b`/`alu_control` are driven directly from S1 regs.
- Retire stage (S2) holds `out_valid`, `out_result`, `out_zero`, and `out_illegal`.
- S2 advance condition: `s2_take = s1_valid & (!out_valid | out_ready)`.
- Accept condition: `in_ready = !reset & !flush & (!s1_valid | s2_take)`. An op is accepted when `in_valid & in_ready`.
- On `s2_take`, S2 captures `alu_result`/`alu_zero`/illegal and sets `out_valid`.
- `s1_valid` is cleared when S1 moves on and nothing new is accepted.
- `out_valid` is cleared when `out_ready & out_valid` and no `s2_take` occurs.
- `retire_count` increments on each `out_valid & out_ready` handshake. It wraps from 0xFFFF to 0.
- `flush` clears `s1_valid` and `out_valid` at the edge. Data regs and `retire_count` are kept. An `out_ready` handshake in the flush cycle still counts.
- Reset has priority over flush. Flush has priority over accept and advance.

## Timing
- Reset values: `s1_valid`=0, `out_valid`=0, `out_result`=0, `out_zero`=0, `out_illegal`=0, `retire_count`=0. `alu_a`/`alu_b`=0 and `alu_control`=0000. `in_ready`=0 while `reset` is high, 1 the first cycle after.
- Latency: an op accepted at edge N drives the ALU during cycle N+1. Its result is registered at edge N+1 and `out_valid` is high in cycle N+1→N+2 (2 edges, accept to visible result) if unstalled.
- Back-to-back ops with `out_ready`=1 give one result per cycle, in order, with no bubbles.
- With `out_ready` held low, at most 2 ops are buffered (S1 + S2). `in_ready` drops the cycle after S1 fills behind a full S2.
- `out_*` remain stable while `out_valid & !out_ready`.
- Reset or flush mid-stream loses in-flight ops. No partial result appears afterwards.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs at reset values; `in_ready`=1 on the first cycle after release.
- R-type AND: A=0x01101111, B=0x00001111, funct 100100 → `alu_control`=0000 in cycle N+1; `out_result`=0x00001111, `out_zero`=0 two edges after accept.
- Back-to-back: add 0x10101111+0x01101111, then sub 0x10101111−0x10101111, then slt 0x00001111<0x01101111 → results 0x11202222, 0x00000000 (`out_zero`=1), 0x00000001 on consecutive cycles; `retire_count`=3.
- Backpressure: `out_ready`=0 while 3 ops are offered → 2 accepted, `in_ready`=0 for the third. First result held stable. Releasing `out_ready` drains the results in order.
- Illegal: `alu_op`=10, funct 000000 → `out_illegal`=1, `alu_control`=0010. Same for `alu_op`=11.
- Flush: S1 and S2 both full, assert `flush` 1 cycle → `out_valid`=0 and `s1_valid`=0 next cycle. `in_ready`=0 during flush. No stale result emerges.
